aes_8bit_host_ctrl: RTL and testbench

//  Host-side initiator for the 8-bit serial AES-128 encryption core.
//  - Accepts a 128-bit key and plaintext over a valid/ready handshake.
//  - Sequences the core: reset, then 16 byte-serial load cycles.
//  - Collects the 16 serial ciphertext bytes into a 128-bit word, presented on a valid/ready output.
//  - Sits between the bus-slave register file and the core.

---
 rtl/aes_8bit_host_ctrl.sv | 144 ++++++++++++++
 tb/tb_aes_8bit_host_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_8bit_host_ctrl.sv
// rtl/aes_8bit_host_ctrl.sv - host-side sequencer for the 8-bit serial AES-128 core
// Loads key/plaintext byte-serially, then gathers 16 ciphertext bytes into one 128-bit word.
module aes_8bit_host_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key,
  input  logic [127:0] pt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ct,
  output logic         busy,
  output logic         err_timeout,
  output logic         core_rst,
  output logic [7:0]   core_key_in,
  output logic [7:0]   core_d_in,
  input  logic [7:0]   core_d_out,
  input  logic         core_d_vld
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] WAIT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CRST,
    S_LOAD,
    S_WAIT,
    S_CAPT,
    S_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [127:0]    key_sr_q, key_sr_d;
  logic [127:0]    pt_sr_q, pt_sr_d;
  logic [127:0]    ct_sr_q, ct_sr_d;
  logic [3:0]      byte_cnt_q, byte_cnt_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      key_sr_q   <= '0;
      pt_sr_q    <= '0;
      ct_sr_q    <= '0;
      byte_cnt_q <= '0;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_sr_q   <= key_sr_d;
      pt_sr_q    <= pt_sr_d;
      ct_sr_q    <= ct_sr_d;
      byte_cnt_q <= byte_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    key_sr_d    = key_sr_q;
    pt_sr_d     = pt_sr_q;
    ct_sr_d     = ct_sr_q;
    byte_cnt_d  = byte_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    err_d       = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    core_rst    = 1'b0;
    core_key_in = 8'h00;
    core_d_in   = 8'h00;

    case (state_q)
      S_IDLE: begin
        core_rst   = 1'b1;
        in_ready   = ~rst;
        byte_cnt_d = '0;
        wait_cnt_d = '0;
        if (in_valid && !rst) begin
          key_sr_d = key;
          pt_sr_d  = pt;
          state_d  = S_CRST;
        end
      end
      S_CRST: begin
        core_rst = 1'b1;
        state_d  = S_LOAD;
      end
      S_LOAD: begin
        core_key_in = key_sr_q[127:120];
        core_d_in   = pt_sr_q[127:120];
        key_sr_d    = {key_sr_q[119:0], 8'h00};
        pt_sr_d     = {pt_sr_q[119:0], 8'h00};
        byte_cnt_d  = byte_cnt_q + 4'd1;
        wait_cnt_d  = '0;
        if (byte_cnt_q == 4'd15) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A byte already valid on the first waiting cycle is byte 0 of the ciphertext.
        if (core_d_vld) begin
          ct_sr_d    = {ct_sr_q[119:0], core_d_out};
          byte_cnt_d = byte_cnt_q + 4'd1;
          state_d    = S_CAPT;
        end else if (wait_cnt_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
      end
      S_CAPT: begin
        if (core_d_vld) begin
          ct_sr_d    = {ct_sr_q[119:0], core_d_out};
          byte_cnt_d = byte_cnt_q + 4'd1;
          if (byte_cnt_q == 4'd15) begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ct          = ct_sr_q;
  assign busy        = (state_q != S_IDLE);
  assign err_timeout = err_q;

endmodule

// File: tb/tb_aes_8bit_host_ctrl.sv
// tb/tb_aes_8bit_host_ctrl.sv - scoreboard bench for aes_8bit_host_ctrl with a stub serial core
// The stub returns the FIPS-197 ciphertext for the FIPS vector and key^pt for any other load.
module tb_aes_8bit_host_ctrl;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] V2_KEY   = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] V2_PT    = 128'hffffffffffffffff0000000000000000;
  localparam logic [127:0] V2_CT    = 128'hfedcba9876543210fedcba9876543210;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] key;
  logic [127:0] pt;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ct;
  logic         busy;
  logic         err_timeout;
  logic         core_rst;
  logic [7:0]   core_key_in;
  logic [7:0]   core_d_in;
  logic [7:0]   core_d_out;
  logic         core_d_vld;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         is_err;
    logic [127:0] ct;
  } exp_t;
  exp_t exp_q[$];

  aes_8bit_host_ctrl #(.TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .key         (key),
    .pt          (pt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ct          (ct),
    .busy        (busy),
    .err_timeout (err_timeout),
    .core_rst    (core_rst),
    .core_key_in (core_key_in),
    .core_d_in   (core_d_in),
    .core_d_out  (core_d_out),
    .core_d_vld  (core_d_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub core: shifts in 16 key/data bytes, waits a few cycles, then streams the result.
  logic         stub_dead;
  logic [127:0] kld, pld, stub_ct;
  int           ld_cnt, dly, out_idx;

  always @(posedge clk) begin
    if (core_rst) begin
      kld <= '0; pld <= '0; ld_cnt <= 0; dly <= 0; out_idx <= 0; core_d_vld <= 1'b0;
    end else if (ld_cnt < 16) begin
      kld    <= {kld[119:0], core_key_in};
      pld    <= {pld[119:0], core_d_in};
      ld_cnt <= ld_cnt + 1;
    end else if (!core_d_vld) begin
      if (!stub_dead) begin
        if (dly == 3) core_d_vld <= 1'b1;
        else dly <= dly + 1;
      end
    end else if (out_idx < 15) begin
      out_idx <= out_idx + 1;
    end
  end

  always_comb begin
    stub_ct    = (kld == FIPS_KEY && pld == FIPS_PT) ? FIPS_CT : (kld ^ pld);
    core_d_out = stub_ct[127 - 8*out_idx -: 8];
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ct handshake or timeout pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ct", ct, 128'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_kind_ct", {127'h0, e.is_err}, 128'h0);
          chk("sb_ct", ct, e.ct);
        end
      end
      if (err_timeout === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_err", 128'h1, 128'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_kind_err", {127'h0, e.is_err}, 128'h1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vector(input logic [127:0] k, input logic [127:0] p,
                            input logic [127:0] exp_ct, input bit dead, input int hold);
    exp_t e;
    e.is_err = dead;
    e.ct     = exp_ct;
    exp_q.push_back(e);

    tick();
    in_valid = 1'b1; key = k; pt = p;
    @(negedge clk);
    chk("hs_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("crst_core_rst", core_rst, 1);
    chk("crst_in_ready", in_ready, 0);
    for (int i = 0; i < 16; i++) begin
      tick();
      @(negedge clk);
      chk("load_core_rst", core_rst, 0);
      chk("load_key_byte", core_key_in, k[127 - 8*i -: 8]);
      chk("load_pt_byte", core_d_in, p[127 - 8*i -: 8]);
    end
    tick();
    @(negedge clk);
    chk("wait_core_rst", core_rst, 0);
    chk("wait_busy", busy, 1);

    if (dead) begin
      int off;
      off = 0;
      for (int j = 1; j <= 20; j++) begin
        tick();
        @(negedge clk);
        chk("to_no_out_valid", out_valid, 0);
        if (err_timeout) begin
          off = j;
          break;
        end
      end
      chk("to_cycle", off, 8);
      chk("to_busy", busy, 0);
      chk("to_core_rst", core_rst, 1);
      tick();
      @(negedge clk);
      chk("to_pulse_width", err_timeout, 0);
    end else begin
      bit found;
      found = 1'b0;
      for (int j = 0; j < 100; j++) begin
        tick();
        @(negedge clk);
        if (out_valid) begin
          found = 1'b1;
          break;
        end
      end
      chk("out_valid_seen", found, 1);
      if (hold > 0) begin
        for (int j = 0; j < hold; j++) begin
          if (j > 0) begin
            tick();
            @(negedge clk);
          end
          chk("hold_out_valid", out_valid, 1);
          chk("hold_ct", ct, exp_ct);
          chk("hold_in_ready", in_ready, 0);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_out_valid", out_valid, 1);
      end
      tick();
      @(negedge clk);
      chk("one_cycle_valid", out_valid, 0);
      chk("back_idle_busy", busy, 0);
      chk("back_idle_in_ready", in_ready, 1);
      chk("ct_kept", ct, exp_ct);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; key = '0; pt = '0; out_ready = 1'b1; stub_dead = 1'b0;

    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_done_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_err", err_timeout, 0);
    chk("rst_ct", ct, 0);
    chk("rst_core_key_in", core_key_in, 0);
    chk("rst_core_d_in", core_d_in, 0);

    run_vector(FIPS_KEY, FIPS_PT, FIPS_CT, 1'b0, 0);
    run_vector(V2_KEY, V2_PT, V2_CT, 1'b0, 0);

    out_ready = 1'b0;
    run_vector(V2_KEY, V2_PT, V2_CT, 1'b0, 20);

    stub_dead = 1'b1;
    run_vector(FIPS_KEY, FIPS_PT, 128'h0, 1'b1, 0);
    stub_dead = 1'b0;
    chk("ct_after_timeout", ct, V2_CT);

    tick();
    in_valid = 1'b1; key = V2_KEY; pt = V2_PT;
    @(negedge clk);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i <= 7; i++) tick();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_load_byte7", core_key_in, V2_KEY[71:64]);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_core_rst", core_rst, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_err", err_timeout, 0);
    chk("abort_in_ready", in_ready, 1);

    run_vector(FIPS_KEY, FIPS_PT, FIPS_CT, 1'b0, 0);

    tick();
    tick();
    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
